// File: rtl/z80_io_responder.sv
// Z80 I/O responder: four registers at BASE_PORT..BASE_PORT+3, programmable wait states, edge interrupt.
// Optional macro Z80IO_IM2_VECTOR_EN adds the VEC register and IM2 vector on acknowledge.
module z80_io_responder #(
   parameter logic [7:0] BASE_PORT = 8'h40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] a,
   input  logic       m1_n,
   input  logic       iorq_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic [7:0] d_in,
   output logic [7:0] d_out,
   output logic       d_oe,
   output logic       wait_n,
   output logic       int_n,
   input  logic [7:0] gpio_in,
   output logic [7:0] gpio_out,
   input  logic       irq_in,
   output logic [1:0] o_dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_cnt;
   logic [2:0] w_cnt_nxt;
   logic [1:0] r_sel;
   logic       r_is_rd;
   logic [7:0] r_rdata;
   logic [7:0] r_data;
   logic [6:0] r_ctrl;
   logic       r_pend;
   logic       r_irq_q;
   logic       r_ack;
   logic       r_blocked;

   logic       w_hit;
   logic       w_ack;
   logic       w_wr_en;
   logic       w_edge;
   logic       w_pend_clr;
   logic [7:0] w_rd_val;
   logic [7:0] w_vec_rd;
   logic [7:0] w_vec_ack;

   // r_blocked keeps a cycle cut short by reset from being re-decoded after release.
   assign w_hit = !r_blocked && !iorq_n && m1_n && (a[7:2] == BASE_PORT[7:2]) && (!rd_n || !wr_n);
   assign w_ack = (r_state == S_IDLE) && !m1_n && !iorq_n && r_pend && r_ctrl[0];
   assign w_wr_en = (r_state == S_ACCESS) && !r_is_rd && !wr_n;
   assign w_edge = irq_in && !r_irq_q;
   assign w_pend_clr = (r_ack && iorq_n) || (w_wr_en && (r_sel == 2'd2) && d_in[7]);

   assign wait_n = (r_state != S_WAIT);
   assign int_n = !(r_pend && r_ctrl[0]);
   assign gpio_out = r_data;
   assign o_dbg_state = r_state;

`ifdef Z80IO_IM2_VECTOR_EN
   logic [7:0] r_vec;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vec <= 8'hFF;
      end else if (w_wr_en && (r_sel == 2'd3)) begin
         r_vec <= d_in;
      end
   end

   assign w_vec_rd = r_vec;
   assign w_vec_ack = {r_vec[7:1], 1'b0};
`else
   assign w_vec_rd = 8'hFF;
   assign w_vec_ack = 8'hFF;
`endif

   always_comb begin
      w_rd_val = 8'hFF;
      case (r_sel)
         2'd0: w_rd_val = r_data;
         2'd1: w_rd_val = gpio_in;
         2'd2: w_rd_val = {r_pend, r_ctrl};
         2'd3: w_rd_val = w_vec_rd;
         default: w_rd_val = 8'hFF;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_hit) begin
               if (r_ctrl[3:1] != 3'd0) begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt = r_ctrl[3:1];
               end else begin
                  w_state_nxt = S_ACCESS;
               end
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - 3'd1;
            if (r_cnt == 3'd1) w_state_nxt = S_ACCESS;
         end
         S_ACCESS: w_state_nxt = S_HOLD;
         S_HOLD: begin
            if (iorq_n) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      d_oe = 1'b0;
      d_out = 8'hFF;
      if (w_ack) begin
         d_oe = 1'b1;
         d_out = w_vec_ack;
      end else if ((r_state == S_ACCESS) && r_is_rd) begin
         d_oe = 1'b1;
         d_out = w_rd_val;
      end else if ((r_state == S_HOLD) && r_is_rd && !iorq_n && !rd_n) begin
         d_oe = 1'b1;
         d_out = r_rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt <= 3'd0;
         r_sel <= 2'd0;
         r_is_rd <= 1'b0;
         r_rdata <= 8'hFF;
         r_data <= 8'h00;
         r_ctrl <= 7'h00;
         r_pend <= 1'b0;
         r_irq_q <= 1'b0;
         r_ack <= 1'b0;
         r_blocked <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt <= w_cnt_nxt;
         if ((r_state == S_IDLE) && w_hit) begin
            r_sel <= a[1:0];
            r_is_rd <= !rd_n;
         end
         if (r_state == S_ACCESS) r_rdata <= w_rd_val;
         if (w_wr_en && (r_sel == 2'd0)) r_data <= d_in;
         if (w_wr_en && (r_sel == 2'd2)) r_ctrl <= d_in[6:0];
         // A new edge outranks any clear landing in the same cycle.
         if (w_edge) r_pend <= 1'b1;
         else if (w_pend_clr) r_pend <= 1'b0;
         r_irq_q <= irq_in;
         if (w_ack) r_ack <= 1'b1;
         else if (iorq_n) r_ack <= 1'b0;
         if (iorq_n) r_blocked <= 1'b0;
      end
   end

endmodule

// File: tb/tb_z80_io_responder.sv
// Directed bench for z80_io_responder: bus-cycle tasks, read-data scoreboard queue, summary report.
module tb_z80_io_responder;

`ifdef Z80IO_IM2_VECTOR_EN
   localparam logic [7:0] VEC_RD = 8'h21;
   localparam logic [7:0] ACK_VEC = 8'h20;
`else
   localparam logic [7:0] VEC_RD = 8'hFF;
   localparam logic [7:0] ACK_VEC = 8'hFF;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] a;
   logic       m1_n, iorq_n, rd_n, wr_n;
   logic [7:0] d_in;
   logic [7:0] d_out;
   logic       d_oe, wait_n, int_n;
   logic [7:0] gpio_in, gpio_out;
   logic       irq_in;
   logic [1:0] dbg_state;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];

   z80_io_responder #(.BASE_PORT(8'h40)) dut (
      .clk(clk), .reset(reset), .a(a), .m1_n(m1_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .wait_n(wait_n), .int_n(int_n),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .irq_in(irq_in), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      a = 8'h00;
      m1_n = 1'b1;
      iorq_n = 1'b1;
      rd_n = 1'b1;
      wr_n = 1'b1;
   endtask

   task automatic io_write(input logic [7:0] addr, input logic [7:0] data, input int exp_wait,
                           input logic irq_at_access);
      int waits;
      a = addr;
      d_in = data;
      iorq_n = 1'b0;
      wr_n = 1'b0;
      tick();
      waits = 0;
      while (!wait_n && waits < 40) begin
         waits++;
         tick();
      end
      chk("wr_wait_cycles", 8'(waits), 8'(exp_wait));
      irq_in = irq_at_access;
      tick();
      irq_in = 1'b0;
      wr_n = 1'b1;
      iorq_n = 1'b1;
      tick();
      a = 8'h00;
   endtask

   task automatic io_read(input logic [7:0] addr, input logic [7:0] exp_val, input int exp_wait);
      int waits;
      logic [7:0] e;
      exp_q.push_back(exp_val);
      a = addr;
      iorq_n = 1'b0;
      rd_n = 1'b0;
      tick();
      waits = 0;
      while (!wait_n && waits < 40) begin
         waits++;
         tick();
      end
      chk("rd_wait_cycles", 8'(waits), 8'(exp_wait));
      chk("rd_oe", {7'd0, d_oe}, 8'd1);
      e = exp_q.pop_front();
      chk("rd_data", d_out, e);
      tick();
      chk("rd_hold_oe", {7'd0, d_oe}, 8'd1);
      chk("rd_hold_data", d_out, e);
      rd_n = 1'b1;
      #1;
      chk("rd_release_oe", {7'd0, d_oe}, 8'd0);
      chk("rd_release_out", d_out, 8'hFF);
      iorq_n = 1'b1;
      tick();
      a = 8'h00;
   endtask

   initial begin
      reset = 1'b1;
      bus_idle();
      irq_in = 1'b0;
      gpio_in = 8'h00;
      d_in = 8'h00;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_wait_n", {7'd0, wait_n}, 8'd1);
      chk("rst_int_n", {7'd0, int_n}, 8'd1);
      chk("rst_d_oe", {7'd0, d_oe}, 8'd0);
      chk("rst_d_out", d_out, 8'hFF);
      chk("rst_gpio_out", gpio_out, 8'h00);

      // Zero-wait OUT to DATA.
      io_write(8'h40, 8'h5A, 0, 1'b0);
      chk("out40_gpio", gpio_out, 8'h5A);

      // WS=3, then register reads.
      io_write(8'h42, 8'h06, 0, 1'b0);
      gpio_in = 8'hC3;
      io_read(8'h41, 8'hC3, 3);
      io_read(8'h42, 8'h06, 3);
      io_read(8'h40, 8'h5A, 3);
      io_write(8'h43, 8'h21, 3, 1'b0);
      io_read(8'h43, VEC_RD, 3);
      io_write(8'h41, 8'h00, 3, 1'b0);
      io_read(8'h40, 8'h5A, 3);

      // IE=1, WS=0; interrupt and acknowledge.
      io_write(8'h42, 8'h01, 3, 1'b0);
      irq_in = 1'b1;
      tick();
      chk("irq_int_n_low", {7'd0, int_n}, 8'd0);
      irq_in = 1'b0;
      tick();
      m1_n = 1'b0;
      iorq_n = 1'b0;
      #1;
      chk("ack_oe", {7'd0, d_oe}, 8'd1);
      chk("ack_vec", d_out, ACK_VEC);
      chk("ack_wait_n", {7'd0, wait_n}, 8'd1);
      tick();
      chk("ack_vec_held", d_out, ACK_VEC);
      chk("ack_wait_n_held", {7'd0, wait_n}, 8'd1);
      iorq_n = 1'b1;
      m1_n = 1'b1;
      tick();
      chk("ack_done_int_n", {7'd0, int_n}, 8'd1);
      chk("ack_done_oe", {7'd0, d_oe}, 8'd0);

      // New edge coinciding with acknowledge completion keeps the request.
      irq_in = 1'b1;
      tick();
      irq_in = 1'b0;
      chk("irq2_int_n_low", {7'd0, int_n}, 8'd0);
      tick();
      m1_n = 1'b0;
      iorq_n = 1'b0;
      tick();
      chk("ack2_vec", d_out, ACK_VEC);
      iorq_n = 1'b1;
      m1_n = 1'b1;
      irq_in = 1'b1;
      tick();
      chk("ack_edge_race_int_n", {7'd0, int_n}, 8'd0);
      irq_in = 1'b0;
      tick();
      chk("pend_kept_int_n", {7'd0, int_n}, 8'd0);
      io_write(8'h42, 8'h81, 0, 1'b0);
      chk("ctrl_clear_int_n", {7'd0, int_n}, 8'd1);

      // Edge coinciding with a CTRL clear also keeps the request.
      io_write(8'h42, 8'h81, 0, 1'b1);
      chk("clr_edge_race_int_n", {7'd0, int_n}, 8'd0);
      io_write(8'h42, 8'h81, 0, 1'b0);
      chk("clr_again_int_n", {7'd0, int_n}, 8'd1);
      io_write(8'h42, 8'h0E, 0, 1'b0);

      // Reset during a WS=7 write.
      a = 8'h40;
      d_in = 8'hAA;
      iorq_n = 1'b0;
      wr_n = 1'b0;
      repeat (3) tick();
      chk("ws7_wait_n_low", {7'd0, wait_n}, 8'd0);
      reset = 1'b1;
      #1;
      chk("midrst_wait_n", {7'd0, wait_n}, 8'd1);
      chk("midrst_d_oe", {7'd0, d_oe}, 8'd0);
      chk("midrst_d_out", d_out, 8'hFF);
      chk("midrst_gpio", gpio_out, 8'h00);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      chk("aborted_gpio", gpio_out, 8'h00);
      chk("aborted_wait_n", {7'd0, wait_n}, 8'd1);
      bus_idle();
      tick();
      io_write(8'h40, 8'h3C, 0, 1'b0);
      chk("post_rst_gpio", gpio_out, 8'h3C);

      // Port miss and opcode fetch are ignored.
      a = 8'h44;
      d_in = 8'hFF;
      iorq_n = 1'b0;
      wr_n = 1'b0;
      repeat (4) tick();
      chk("miss_wait_n", {7'd0, wait_n}, 8'd1);
      chk("miss_d_oe", {7'd0, d_oe}, 8'd0);
      chk("miss_gpio", gpio_out, 8'h3C);
      bus_idle();
      tick();
      a = 8'h40;
      m1_n = 1'b0;
      rd_n = 1'b0;
      repeat (3) tick();
      chk("m1_fetch_d_oe", {7'd0, d_oe}, 8'd0);
      rd_n = 1'b1;
      iorq_n = 1'b0;
      tick();
      chk("m1_iorq_noint_d_oe", {7'd0, d_oe}, 8'd0);
      chk("m1_iorq_noint_d_out", d_out, 8'hFF);
      bus_idle();
      tick();
      io_read(8'h40, 8'h3C, 0);
      io_read(8'h42, 8'h00, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/z80_io_responder.md
Z80_IO_RESPONDER -- requirements
Module: z80_io_responder

Interface
REQ-001 Parameter BASE_PORT, default 8'h40, I/O base port; the block decodes BASE_PORT..BASE_PORT+3 (a[1:0] = register select).
REQ-002 clk  in  1  system clock, same clock as the CPU core; all bus inputs are synchronous to it.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 a  in  8  CPU address bits 7:0.
REQ-005 m1_n, iorq_n, rd_n, wr_n  in  1 each  CPU bus strobes, active low.
REQ-006 d_in  in  8  CPU write data.
REQ-007 d_out  out  8  read data or interrupt vector driven toward the CPU.
REQ-008 d_oe  out  1  high while d_out is valid for the CPU.
REQ-009 wait_n  out  1  wait request to the CPU, active low.
REQ-010 int_n  out  1  maskable interrupt request to the CPU, active low.
REQ-011 gpio_in  in  8  external input port; gpio_out  out  8  external output latch.
REQ-012 irq_in  in  1  external interrupt source, rising-edge sensitive.

Function
REQ-013 Registers: 0 DATA (R/W, drives gpio_out); 1 INPUT (R, returns gpio_in); 2 CTRL (R/W; bit0 IE, bits3:1 WS wait count, bit7 PEND read-only, write 1 to clear); 3 VEC (R/W IM2 vector).
REQ-014 Cycle hit: iorq_n=0, m1_n=1, a[7:2]=BASE_PORT[7:2], and (rd_n=0 or wr_n=0).
REQ-015 FSM states: IDLE, WAIT, ACCESS, HOLD.
REQ-016 IDLE->WAIT on hit with WS>0, loading a counter with WS; IDLE->ACCESS on hit with WS=0.
REQ-017 In WAIT, wait_n=0 and the counter decrements once per clk; at count 1 the FSM moves to ACCESS, so wait_n is low for exactly WS cycles.
REQ-018 In ACCESS, a write with wr_n=0 updates the selected register exactly once; a read sets d_oe=1 and d_out=register value; then ACCESS->HOLD.
REQ-019 In HOLD, read data stays driven until iorq_n=1 or rd_n=1; HOLD->IDLE when iorq_n=1; no further write takes effect in the same cycle.
REQ-020 Writes to INPUT are ignored; bit7 is zero in the write path of CTRL.
REQ-021 d_oe=0 and d_out=8'hFF whenever no read or acknowledge is being served.
REQ-022 Rising-edge detector on irq_in sets PEND; int_n = ~(PEND & IE).
REQ-023 Interrupt acknowledge: m1_n=0 and iorq_n=0 with int_n=0 drives d_oe=1, d_out=vector (see REQ-029) and never asserts wait_n; PEND clears when iorq_n returns high.
REQ-024 Same-cycle irq_in edge and acknowledge completion: PEND remains set (new request wins).
REQ-025 Same-cycle irq_in edge and CTRL write of bit7=1: PEND remains set.
REQ-026 A port miss or an M1 opcode fetch never changes state or drives d_oe.

Reset
REQ-027 Reset forces FSM=IDLE, counter=0, DATA=8'h00 (gpio_out=8'h00), CTRL=8'h00, VEC=8'hFF, PEND=0, edge-detector history=0, wait_n=1, int_n=1, d_oe=0, d_out=8'hFF.
REQ-028 Reset asserted mid-cycle aborts it immediately; after release the block ignores the aborted cycle and returns to IDLE until iorq_n=1.

Configuration
REQ-029 With macro Z80IO_IM2_VECTOR_EN defined, the acknowledge returns {VEC[7:1],1'b0}, and VEC is read/write.
REQ-030 Without Z80IO_IM2_VECTOR_EN, the acknowledge returns 8'hFF (RST 38h, for IM1 or IM0), VEC is not implemented, writes to register 3 are ignored, and reads return 8'hFF.

Verification
REQ-031 WS=0, OUT (40h),5Ah -> gpio_out=8'h5A after the cycle; wait_n stays high throughout.
REQ-032 CTRL=8'h06 (WS=3), IN (41h) with gpio_in=8'hC3 -> wait_n low for exactly 3 clk, then d_oe=1 and d_out=8'hC3 until rd_n rises.
REQ-033 IE=1, irq_in pulse -> int_n=0 next clk; acknowledge with VEC=8'h21 -> d_out=8'h20 (macro on) or 8'hFF (macro off); int_n=1 after iorq_n rises.
REQ-034 irq_in edge on the same clk that acknowledge ends -> int_n stays 0; CTRL write 8'h81 -> PEND cleared, int_n=1.
REQ-035 Reset pulse during WAIT with WS=7 -> wait_n=1 and d_oe=0 immediately; a write in progress leaves DATA=8'h00.
REQ-036 OUT (44h),FFh and M1 fetch at address 8'h40 -> no register change, d_oe=0.
